sram_port_arbiter: RTL and testbench

- Two-requester controller for the word-addressed SRAM array: port 0 is instruction fetch, port 1 is load/store.
- Arbitrates between the two ports and decodes the word index into a one-hot wordline vector.
- Drives byte select, enables and write data to the array, then captures read data and returns a response to the granted port.
- Sits between the core's memory interfaces and the DEPTH-word array of 32-bit byte-selectable words.

---
 rtl/sram_port_arbiter_pkg.sv | 16 +
 rtl/sram_port_arbiter_if.sv | 26 ++
 rtl/sram_port_arbiter_wl_decode.sv | 16 +
 rtl/sram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } sram_arb_state_t;

  localparam int SRAM_WORD_W = 32;
  localparam int SRAM_BYTES  = 4;
  localparam int PORT_IF     = 0;
  localparam int PORT_LS     = 1;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: both ports' request fields and responses.
import sram_pkg::*;

interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic [1:0]                       req_i;
  logic [1:0]                       we_i;
  logic [1:0][ADDR_W-1:0]           addr_i;
  logic [1:0][SRAM_WORD_W-1:0]      wdata_i;
  logic [1:0][SRAM_BYTES-1:0]       be_i;
  logic [1:0]                       gnt_o;
  logic [1:0]                       rsp_valid_o;
  logic                             rsp_err_o;
  logic [SRAM_WORD_W-1:0]           rdata_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rsp_valid_o, rsp_err_o, rdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rsp_valid_o, rsp_err_o, rdata_o
  );
endinterface

// File: rtl/sram_port_arbiter_wl_decode.sv
// Word index to one-hot wordline decoder with enable.
module sram_wl_decode #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [DEPTH-1:0] wl_o
);

  always_comb begin
    wl_o = '0;
    if (en_i) wl_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port SRAM arbiter: grant, one ACCESS cycle to the array, read capture, response.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 1.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_port_arbiter_if.slave     bus,
  output logic [DEPTH-1:0]       sram_wl_o,
  output logic [SRAM_BYTES-1:0]  sram_bsel_o,
  output logic [SRAM_WORD_W-1:0] sram_din_o,
  output logic                   sram_re_o,
  output logic                   sram_we_o,
  input  logic [SRAM_WORD_W-1:0] sram_dout_i
);

  localparam int IDX_W = $clog2(DEPTH);

  sram_arb_state_t        state_q, state_d;
  logic                   port_q, we_q, err_q;
  logic [IDX_W-1:0]       idx_q;
  logic [SRAM_WORD_W-1:0] wdata_q, rdata_q;
  logic [SRAM_BYTES-1:0]  be_q;

  logic                   win, grant, win_oor, wl_en;
  logic [ADDR_W-1:0]      win_addr;
  logic                   unused_addr_bits;

`ifdef SRAM_ARB_RR_EN
  logic ptr_q;

  // On a tie the pointer names the winner; it toggles after every grant.
  always_comb begin
    win = bus.req_i[PORT_LS];
    if (&bus.req_i) win = ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     ptr_q <= 1'b0;
    else if (grant) ptr_q <= ~ptr_q;
  end
`else
  assign win = bus.req_i[PORT_LS];
`endif

  assign grant            = rst_n && (state_q == IDLE) && (|bus.req_i);
  assign bus.gnt_o        = grant ? (2'b01 << win) : 2'b00;
  assign win_addr         = bus.addr_i[win];
  assign win_oor          = |win_addr[ADDR_W-1:IDX_W+2];
  assign unused_addr_bits = ^win_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        port_q <= win;
        we_q   <= bus.we_i[win];
        err_q  <= win_oor;
      end
    end
  end

  // Datapath holding registers: only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    if (grant) begin
      idx_q   <= win_addr[IDX_W+1:2];
      wdata_q <= bus.wdata_i[win];
      be_q    <= bus.be_i[win];
    end
    if (state_q == WAIT) rdata_q <= sram_dout_i;
  end

  always_comb begin
    state_d         = state_q;
    wl_en           = 1'b0;
    sram_re_o       = 1'b0;
    sram_we_o       = 1'b0;
    sram_bsel_o     = '0;
    sram_din_o      = '0;
    bus.rsp_valid_o = 2'b00;
    bus.rsp_err_o   = 1'b0;
    bus.rdata_o     = '0;
    case (state_q)
      IDLE: if (grant) state_d = win_oor ? RESP : ACCESS;
      ACCESS: begin
        wl_en = 1'b1;
        if (we_q) begin
          sram_we_o   = 1'b1;
          sram_bsel_o = be_q;
          sram_din_o  = wdata_q;
        end else begin
          sram_re_o   = 1'b1;
          sram_bsel_o = '1;
        end
        state_d = WAIT;
      end
      WAIT: state_d = RESP;
      RESP: begin
        bus.rsp_valid_o[port_q] = 1'b1;
        bus.rsp_err_o           = err_q;
        bus.rdata_o             = (we_q || err_q) ? '0 : rdata_q;
        state_d                 = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sram_wl_decode #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_wl_decode (
    .en_i  (wl_en),
    .idx_i (idx_q),
    .wl_o  (sram_wl_o)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a byte-writable array model.
module tb_sram_port_arbiter;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic [DEPTH-1:0]  sram_wl;
  logic [3:0]        sram_bsel;
  logic [31:0]       sram_din;
  logic              sram_re, sram_we;
  logic [31:0]       sram_dout;

  int n_assert = 0;
  int n_fail   = 0;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sram_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sram_wl_o   (sram_wl),
    .sram_bsel_o (sram_bsel),
    .sram_din_o  (sram_din),
    .sram_re_o   (sram_re),
    .sram_we_o   (sram_we),
    .sram_dout_i (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: byte-masked write, registered read on the ACCESS edge.
  logic [31:0] mem [DEPTH];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      mem[2]     <= 32'hAABBCCDD;
      mem_loaded <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sram_wl[i]) begin
          if (sram_we)
            for (int b = 0; b < 4; b++)
              if (sram_bsel[b]) mem[i][8*b +: 8] <= sram_din[8*b +: 8];
          if (sram_re) sram_dout <= mem[i];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    bus.we_i[p]    = w;
    bus.addr_i[p]  = a;
    bus.wdata_i[p] = d;
    bus.be_i[p]    = b;
    bus.req_i[p]   = 1'b1;
  endtask

  task automatic wait_gnt();
    int n = 0;
    #1;
    while (bus.gnt_o == 2'b00 && n < 16) begin
      tick();
      n++;
    end
    if (bus.gnt_o == 2'b00) check("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {bus.gnt_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rdata_o,
                          sram_re, sram_we, sram_bsel, sram_din}, 64'd0);
    check({tag, "_wl"}, sram_wl, 64'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.req_i = 2'b00;
    repeat (3) tick();
    check_quiet("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_tie [4];
    logic [1:0] exp_after_rst;
    logic [1:0] seen;
`ifdef SRAM_ARB_RR_EN
    exp_tie       = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_after_rst = 2'b01;
`else
    exp_tie       = '{2'b10, 2'b10, 2'b10, 2'b10};
    exp_after_rst = 2'b10;
`endif
    bus.req_i = 2'b00; bus.we_i = 2'b00; bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
    do_reset();

    // Port 1 full-word write to word 4
    set_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_gnt();
    check("wr_gnt", bus.gnt_o, 2'b10);
    tick(); bus.req_i = 2'b00;
    check("wr_wl", sram_wl, 64'h10);
    check("wr_en", {sram_we, sram_re}, 2'b10);
    check("wr_bsel", sram_bsel, 4'hF);
    check("wr_din", sram_din, 32'hDEADBEEF);
    tick();
    check("wr_wait_quiet", {sram_wl, sram_we, sram_re}, 66'd0);
    tick();
    check("wr_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rdata_o}, {2'b10, 1'b0, 32'h0});
    tick();
    check("wr_rsp_done", bus.rsp_valid_o, 2'b00);

    // Port 0 read back of word 4
    set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_gnt();
    check("rd_gnt", bus.gnt_o, 2'b01);
    tick(); bus.req_i = 2'b00;
    check("rd_en", {sram_we, sram_re, sram_bsel, sram_din}, {2'b01, 4'hF, 32'h0});
    check("rd_wl", sram_wl, 64'h10);
    tick(); tick();
    check("rd_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rdata_o}, {2'b01, 1'b0, 32'hDEADBEEF});
    tick();

    // Partial write to word 2, then a be=0 write, then read back
    set_req(1, 1'b1, 32'h8, 32'h11223344, 4'b0101);
    wait_gnt();
    tick(); bus.req_i = 2'b00;
    check("pw_bsel", sram_bsel, 4'b0101);
    check("pw_wl", sram_wl, 64'h4);
    tick(); tick(); tick();
    set_req(1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0);
    wait_gnt();
    tick(); bus.req_i = 2'b00;
    check("be0_access", {sram_we, sram_bsel}, {1'b1, 4'h0});
    tick(); tick();
    check("be0_rsp", {bus.rsp_valid_o, bus.rsp_err_o}, {2'b10, 1'b0});
    tick();
    set_req(0, 1'b0, 32'h8, 32'h0, 4'h0);
    wait_gnt();
    tick(); bus.req_i = 2'b00;
    tick(); tick();
    check("pw_readback", bus.rdata_o, 32'hAA22CC44);
    tick();

    // Out-of-range read: error after one cycle, array never enabled
    set_req(0, 1'b0, 32'h100, 32'h0, 4'h0);
    wait_gnt();
    check("err_gnt", bus.gnt_o, 2'b01);
    check("err_t0_quiet", {sram_wl, sram_we, sram_re}, 66'd0);
    tick(); bus.req_i = 2'b00;
    check("err_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rdata_o}, {2'b01, 1'b1, 32'h0});
    check("err_t1_quiet", {sram_wl, sram_we, sram_re}, 66'd0);
    tick();
    check("err_done", {bus.rsp_valid_o, sram_wl, sram_we, sram_re}, 68'd0);

    // Both ports held high for four transactions
    do_reset();
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h4, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      wait_gnt();
      check($sformatf("tie_gnt%0d", k), bus.gnt_o, exp_tie[k]);
      tick();
    end
    bus.req_i = 2'b00;
    tick(); tick(); tick();

    // Reset asserted in the ACCESS cycle of a port 1 read
    set_req(1, 1'b0, 32'h4, 32'h0, 4'h0);
    wait_gnt();
    check("mid_gnt", bus.gnt_o, 2'b10);
    tick(); bus.req_i = 2'b00;
    check("mid_access", sram_re, 1'b1);
    rst_n = 1'b0;
    tick();
    check_quiet("mid_rst");
    rst_n = 1'b1;
    seen = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen |= bus.rsp_valid_o;
    end
    check("mid_no_rsp", seen, 2'b00);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h4, 32'h0, 4'h0);
    wait_gnt();
    check("post_rst_gnt", bus.gnt_o, exp_after_rst);
    tick(); bus.req_i = 2'b00;
    tick(); tick();
    check("post_rst_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rdata_o}, {exp_after_rst, 1'b0, 32'h0});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
